// File: rtl/vec_mau_if.sv
// vec_mau_if: command, vector-register-file and memory-network signals of the
// vector memory access unit, bundled with direction views for each side.
interface vec_mau_if;
   logic        start;
   logic        op_store;
   logic [8:0]  base;
   logic [8:0]  stride;
   logic [4:0]  vlen;
   logic [3:0]  vr_idx;
   logic [31:0] vr_rdata;
   logic [31:0] vr_wdata;
   logic        vr_we;
   logic [8:0]  mem_addr;
   logic        mem_rw;
   logic        mem_enable;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_halt;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        err;

   // Unit side: receives commands and data, drives strobes and addresses.
   modport master (
      input  start, op_store, base, stride, vlen, vr_rdata, mem_rdata, mem_halt, mem_ack,
      output vr_idx, vr_wdata, vr_we, mem_addr, mem_rw, mem_enable, mem_wdata, busy, done, err
   );

   // Environment side: command source, register file and memory network.
   modport slave (
      output start, op_store, base, stride, vlen, vr_rdata, mem_rdata, mem_halt, mem_ack,
      input  vr_idx, vr_wdata, vr_we, mem_addr, mem_rw, mem_enable, mem_wdata, busy, done, err
   );
endinterface

// File: rtl/vec_mau.sv
// vec_mau: strided vector load/store sequencer between a vector register file
// and a banked memory network. One element is issued at a time; an element
// completes on mem_ack, after which the address advances by the stride
// (modulo 512). Load data and its write strobe are registered, so vr_we and
// vr_wdata appear in the cycle after the element's mem_ack; done is likewise
// registered and pulses in the cycle after FIN.
// Optional feature: define MAU_TIMEOUT_EN to build in a 16-cycle WAIT watchdog
// that aborts the vector and raises err.
module vec_mau (
   input logic      clk,
   input logic      reset,
   vec_mau_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        op_store_r;
   logic [8:0]  stride_r;
   logic [4:0]  vlen_r;
   logic [3:0]  idx_r;
   logic [8:0]  cur_addr_r;
   logic [31:0] vr_wdata_r;
   logic        vr_we_r;
   logic        done_r;
   logic        err_r;
   logic        accept_s;
   logic        complete_s;
   logic        timeout_s;
   logic        last_s;
   logic        active_s;
   logic        wdog_hit_s;

`ifdef MAU_TIMEOUT_EN
   logic [3:0]  wdog_r;

   assign wdog_hit_s = (wdog_r == 4'd15);

   // Watchdog: counts consecutive WAIT cycles without ack, cleared otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_r <= 4'd0;
      end else if ((state_r == WAIT) && !bus.mem_ack && !wdog_hit_s) begin
         wdog_r <= wdog_r + 4'd1;
      end else begin
         wdog_r <= 4'd0;
      end
   end
`else
   assign wdog_hit_s = 1'b0;
`endif

   assign accept_s = (state_r == IDLE) && bus.start;
   assign last_s   = ({1'b0, idx_r} == (vlen_r - 5'd1));
   assign active_s = (state_r == ISSUE) || (state_r == WAIT);

   // Next-state decode; mem_ack takes priority over mem_halt and the watchdog.
   always_comb begin
      state_s    = state_r;
      complete_s = 1'b0;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s = (bus.vlen != 5'd0) ? ISSUE : FIN;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (bus.mem_ack) begin
               complete_s = 1'b1;
               state_s    = last_s ? FIN : ISSUE;
            end else if (bus.mem_halt) begin
               state_s = ISSUE;
            end else begin
               state_s = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_ack) begin
               complete_s = 1'b1;
               state_s    = last_s ? FIN : ISSUE;
            end else if (wdog_hit_s) begin
               timeout_s = 1'b1;
               state_s   = FIN;
            end else begin
               state_s = WAIT;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Command latch, element index and address walker (wraps modulo 512).
   always_ff @(posedge clk) begin
      if (reset) begin
         op_store_r <= 1'b0;
         stride_r   <= 9'd0;
         vlen_r     <= 5'd0;
         idx_r      <= 4'd0;
         cur_addr_r <= 9'd0;
      end else if (accept_s) begin
         op_store_r <= bus.op_store;
         stride_r   <= bus.stride;
         vlen_r     <= bus.vlen;
         idx_r      <= 4'd0;
         cur_addr_r <= bus.base;
      end else if (complete_s) begin
         idx_r      <= idx_r + 4'd1;
         cur_addr_r <= cur_addr_r + stride_r;
      end
   end

   // Registered load write-back, completion pulse and sticky abort flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         vr_wdata_r <= 32'd0;
         vr_we_r    <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         vr_we_r <= complete_s && !op_store_r;
         if (complete_s && !op_store_r) begin
            vr_wdata_r <= bus.mem_rdata;
         end
         done_r <= (state_r == FIN);
         if (accept_s) begin
            err_r <= 1'b0;
         end else if (timeout_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign bus.vr_idx     = idx_r;
   assign bus.vr_wdata   = vr_wdata_r;
   assign bus.vr_we      = vr_we_r;
   assign bus.mem_enable = active_s;
   assign bus.mem_addr   = active_s ? cur_addr_r : 9'd0;
   assign bus.mem_rw     = active_s && op_store_r;
   assign bus.mem_wdata  = (active_s && op_store_r) ? bus.vr_rdata : 32'd0;
   assign bus.busy       = (state_r != IDLE);
   assign bus.done       = done_r;
   assign bus.err        = err_r;

endmodule

// File: tb/tb_vec_mau.sv
// tb_vec_mau: directed bench for vec_mau. A trivial register file returns
// 0xA0+vr_idx and a trivial memory returns address*2. Outputs are sampled on
// the falling clock edge; inputs change there too.
module tb_vec_mau;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   vec_mau_if bus ();

   vec_mau dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.mem_rdata = {22'd0, bus.mem_addr, 1'b0};
   assign bus.vr_rdata  = 32'h0000_00A0 + {28'd0, bus.vr_idx};

   logic [82:0] all_out;
   assign all_out = {bus.vr_idx, bus.vr_wdata, bus.vr_we, bus.mem_addr, bus.mem_rw,
                     bus.mem_enable, bus.mem_wdata, bus.busy, bus.done, bus.err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue a one-cycle start; returns at the falling edge after the start edge.
   task automatic do_start(input logic op, input logic [8:0] b, input logic [8:0] s,
                           input logic [4:0] n);
      bus.start    = 1'b1;
      bus.op_store = op;
      bus.base     = b;
      bus.stride   = s;
      bus.vlen     = n;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.base     = 9'd0;
      bus.stride   = 9'd0;
      bus.vlen     = 5'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (all_out !== 83'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load();
      logic [8:0]  addr_tab [4] = '{9'd5, 9'd8, 9'd11, 9'd14};
      logic [31:0] data_tab [4] = '{32'd10, 32'd16, 32'd22, 32'd28};
      bus.mem_ack = 1'b1;
      do_start(1'b0, 9'd5, 9'd3, 5'd4);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({bus.mem_enable, bus.mem_rw, bus.mem_addr, bus.vr_idx} !==
             {1'b1, 1'b0, addr_tab[k], 4'(k)}) begin
            miscompares++;
            $display("FAIL load_issue[%0d]: got en=%b rw=%b addr=%0d idx=%0d want en=1 rw=0 addr=%0d idx=%0d",
                     k, bus.mem_enable, bus.mem_rw, bus.mem_addr, bus.vr_idx, addr_tab[k], k);
         end
         vectors++;
         if (k == 0) begin
            if (bus.vr_we !== 1'b0) begin
               miscompares++;
               $display("FAIL load_we_first: got %b want 0", bus.vr_we);
            end
         end else if ({bus.vr_we, bus.vr_wdata} !== {1'b1, data_tab[k-1]}) begin
            miscompares++;
            $display("FAIL load_wb[%0d]: got we=%b data=%0d want we=1 data=%0d",
                     k - 1, bus.vr_we, bus.vr_wdata, data_tab[k-1]);
         end
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      vectors++;
      if ({bus.vr_we, bus.vr_wdata, bus.busy, bus.done, bus.mem_enable} !==
          {1'b1, 32'd28, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL load_fin: got we=%b data=%0d busy=%b done=%b en=%b want we=1 data=28 busy=1 done=0 en=0",
                  bus.vr_we, bus.vr_wdata, bus.busy, bus.done, bus.mem_enable);
      end
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy, bus.vr_we} !== 3'b100) begin
         miscompares++;
         $display("FAIL load_done: got done=%b busy=%b we=%b want done=1 busy=0 we=0",
                  bus.done, bus.busy, bus.vr_we);
      end
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL load_done_pulse: got %b want 0", bus.done);
      end
   endtask

   task automatic test_store();
      logic [8:0]  addr_tab [3] = '{9'd508, 9'd510, 9'd0};
      logic [31:0] data_tab [3] = '{32'h0A0, 32'h0A1, 32'h0A2};
      bus.mem_ack = 1'b1;
      do_start(1'b1, 9'd508, 9'd2, 5'd3);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({bus.mem_enable, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.vr_we} !==
             {1'b1, 1'b1, addr_tab[k], data_tab[k], 1'b0}) begin
            miscompares++;
            $display("FAIL store[%0d]: got en=%b rw=%b addr=%0d wdata=%h we=%b want en=1 rw=1 addr=%0d wdata=%h we=0",
                     k, bus.mem_enable, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.vr_we,
                     addr_tab[k], data_tab[k]);
         end
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      vectors++;
      if ({bus.vr_we, bus.busy, bus.mem_rw, bus.mem_wdata} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL store_fin: got we=%b busy=%b rw=%b wdata=%h want we=0 busy=1 rw=0 wdata=0",
                  bus.vr_we, bus.busy, bus.mem_rw, bus.mem_wdata);
      end
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.vr_we} !== 2'b10) begin
         miscompares++;
         $display("FAIL store_done: got done=%b we=%b want done=1 we=0", bus.done, bus.vr_we);
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      bus.mem_halt = 1'b1;
      bus.mem_ack  = 1'b0;
      do_start(1'b0, 9'd100, 9'd7, 5'd1);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({bus.mem_enable, bus.mem_addr, bus.vr_idx, bus.vr_we, bus.busy} !==
             {1'b1, 9'd100, 4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got en=%b addr=%0d idx=%0d we=%b busy=%b want en=1 addr=100 idx=0 we=0 busy=1",
                     k, bus.mem_enable, bus.mem_addr, bus.vr_idx, bus.vr_we, bus.busy);
         end
         if (k < 2) @(negedge clk);
      end
      bus.mem_halt = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.mem_enable, bus.mem_addr, bus.vr_idx, bus.vr_we} !== {1'b1, 9'd100, 4'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL stall_wait: got en=%b addr=%0d idx=%0d we=%b want en=1 addr=100 idx=0 we=0",
                  bus.mem_enable, bus.mem_addr, bus.vr_idx, bus.vr_we);
      end
      bus.mem_ack  = 1'b1;
      bus.mem_halt = 1'b1;
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.mem_halt = 1'b0;
      vectors++;
      if ({bus.vr_we, bus.vr_wdata, bus.mem_enable, bus.busy} !== {1'b1, 32'd200, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL stall_ack_priority: got we=%b data=%0d en=%b busy=%b want we=1 data=200 en=0 busy=1",
                  bus.vr_we, bus.vr_wdata, bus.mem_enable, bus.busy);
      end
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_done: got %b want 1", bus.done);
      end
      @(negedge clk);
   endtask

   task automatic test_vlen0();
      bus.mem_ack = 1'b0;
      do_start(1'b0, 9'd7, 9'd1, 5'd0);
      vectors++;
      if ({bus.busy, bus.done, bus.mem_enable} !== 3'b100) begin
         miscompares++;
         $display("FAIL vlen0_fin: got busy=%b done=%b en=%b want busy=1 done=0 en=0",
                  bus.busy, bus.done, bus.mem_enable);
      end
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.done, bus.mem_enable} !== 3'b010) begin
         miscompares++;
         $display("FAIL vlen0_done: got busy=%b done=%b en=%b want busy=0 done=1 en=0",
                  bus.busy, bus.done, bus.mem_enable);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      bus.mem_ack = 1'b1;
      do_start(1'b0, 9'd20, 9'd1, 5'd8);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.vr_idx, bus.mem_addr} !== {4'd2, 9'd22}) begin
         miscompares++;
         $display("FAIL midreset_pre: got idx=%0d addr=%0d want idx=2 addr=22", bus.vr_idx, bus.mem_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (all_out !== 83'd0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got %h want 0", all_out);
      end
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.vr_we} !== 2'b00) begin
         miscompares++;
         $display("FAIL midreset_idle_ack: got busy=%b we=%b want busy=0 we=0", bus.busy, bus.vr_we);
      end
      do_start(1'b0, 9'd40, 9'd4, 5'd2);
      vectors++;
      if ({bus.mem_addr, bus.vr_idx} !== {9'd40, 4'd0}) begin
         miscompares++;
         $display("FAIL rerun_e0: got addr=%0d idx=%0d want addr=40 idx=0", bus.mem_addr, bus.vr_idx);
      end
      @(negedge clk);
      vectors++;
      if ({bus.mem_addr, bus.vr_we, bus.vr_wdata} !== {9'd44, 1'b1, 32'd80}) begin
         miscompares++;
         $display("FAIL rerun_e1: got addr=%0d we=%b data=%0d want addr=44 we=1 data=80",
                  bus.mem_addr, bus.vr_we, bus.vr_wdata);
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      vectors++;
      if ({bus.vr_we, bus.vr_wdata, bus.busy} !== {1'b1, 32'd88, 1'b1}) begin
         miscompares++;
         $display("FAIL rerun_fin: got we=%b data=%0d busy=%b want we=1 data=88 busy=1",
                  bus.vr_we, bus.vr_wdata, bus.busy);
      end
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL rerun_done: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bus.mem_ack  = 1'b0;
      bus.mem_halt = 1'b0;
      do_start(1'b0, 9'd3, 9'd1, 5'd1);
`ifdef MAU_TIMEOUT_EN
      // one ISSUE cycle followed by sixteen WAIT cycles
      for (int k = 0; k < 17; k++) begin
         vectors++;
         if ({bus.busy, bus.err, bus.mem_enable} !== 3'b101) begin
            miscompares++;
            $display("FAIL timeout_wait[%0d]: got busy=%b err=%b en=%b want busy=1 err=0 en=1",
                     k, bus.busy, bus.err, bus.mem_enable);
         end
         @(negedge clk);
      end
      vectors++;
      if ({bus.busy, bus.err, bus.mem_enable, bus.vr_we} !== 4'b1100) begin
         miscompares++;
         $display("FAIL timeout_abort: got busy=%b err=%b en=%b we=%b want busy=1 err=1 en=0 we=0",
                  bus.busy, bus.err, bus.mem_enable, bus.vr_we);
      end
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.err, bus.busy} !== 3'b110) begin
         miscompares++;
         $display("FAIL timeout_done: got done=%b err=%b busy=%b want done=1 err=1 busy=0",
                  bus.done, bus.err, bus.busy);
      end
      @(negedge clk);
      do_start(1'b0, 9'd0, 9'd1, 5'd0);
      vectors++;
      if (bus.err !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_err_clear: got %b want 0", bus.err);
      end
      @(negedge clk);
      @(negedge clk);
`else
      for (int k = 0; k < 30; k++) begin
         vectors++;
         if ({bus.busy, bus.err, bus.mem_enable} !== 3'b101) begin
            miscompares++;
            $display("FAIL no_timeout[%0d]: got busy=%b err=%b en=%b want busy=1 err=0 en=1",
                     k, bus.busy, bus.err, bus.mem_enable);
         end
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
`endif
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.op_store = 1'b0;
      bus.base     = 9'd0;
      bus.stride   = 9'd0;
      bus.vlen     = 5'd0;
      bus.mem_halt = 1'b0;
      bus.mem_ack  = 1'b0;
      @(negedge clk);
      test_reset();
      test_load();
      test_store();
      test_stall();
      test_vlen0();
      test_mid_reset();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
